// File: rtl/seq_div_8by4_if.sv
// seq_div_8by4_if
// Purpose: bundles the start/busy/done handshake, the operands and the results
//          of the 8-by-4 sequential divider into a single port.
// Signals:
//   start - request from the controller, taken only while the divider is idle
//   z     - DW-bit dividend (the multiplier product word)
//   y     - VW-bit divisor (the known multiplier factor)
//   busy  - divide in progress
//   done  - one-cycle pulse; results are valid from this cycle on
//   q     - DW-bit quotient
//   r     - VW-bit remainder
//   ovf   - quotient is too wide to be a VW-bit factor
//   dz    - divisor was zero
// Modports: master drives the request side, slave is the divider itself.
interface seq_div_8by4_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] z;
  logic [VW-1:0] y;
  logic          busy;
  logic          done;
  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic          ovf;
  logic          dz;

  modport master (
    output start, z, y,
    input  busy, done, q, r, ovf, dz
  );

  modport slave (
    input  start, z, y,
    output busy, done, q, r, ovf, dz
  );
endinterface

// File: rtl/seq_div_8by4.sv
// seq_div_8by4
// Purpose: iterative restoring divider, the inverse of the 4x4 array
//          multiplier. From the product word Z and one factor Y it recovers
//          the other factor as quotient Q, plus remainder R. One quotient bit
//          is produced per clock.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - seq_div_8by4_if.slave: start/z/y in, busy/done/q/r/ovf/dz out
module seq_div_8by4 #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_div_8by4_if.slave   bus
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count;
  logic [DW-1:0] dvd;
  logic [VW-1:0] rem;
  logic [VW-1:0] dsr;
  logic [DW-1:0] q_r;
  logic [VW-1:0] r_r;
  logic          ovf_r;
  logic          dz_r;
  logic          busy_o;
  logic          done_o;
  logic [VW:0]   rem_sh;
  logic [VW:0]   trial;
  logic          fits;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. RUN keeps going until the iteration counter is
  // exhausted; the count==0 cycle is spent registering the results.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (count == '0) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic. FIN drops busy and pulses done for exactly one cycle.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state)
      RUN:     busy_o = 1'b1;
      FIN:     done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy = busy_o;
  assign bus.done = done_o;
  assign bus.q    = q_r;
  assign bus.r    = r_r;
  assign bus.ovf  = ovf_r;
  assign bus.dz   = dz_r;

  // The partial remainder is always below the divisor, so after shifting in
  // the next dividend bit it fits in VW+1 bits.
  assign rem_sh = {rem, dvd[DW-1]};

  // Trial subtraction rem_sh - {0,y} as a ripple of full-adder cells adding
  // the inverted divisor with a carry-in of one. The top sum bit is the sign:
  // clear means the divisor fits and the quotient bit is 1.
  always_comb begin
    logic c;
    logic a;
    logic b;
    trial = '0;
    c     = 1'b1;
    for (int i = 0; i <= VW; i++) begin
      a        = rem_sh[i];
      b        = (i < VW) ? ~dsr[i] : 1'b1;
      trial[i] = a ^ b ^ c;
      c        = (a & b) | (c & (a ^ b));
    end
  end

  assign fits = ~trial[VW];

  // Datapath. The dividend register doubles as the quotient shift register:
  // each step moves one dividend bit out at the top and one quotient bit in
  // at the bottom. A zero divisor skips the iterations entirely so the
  // result is ready one edge after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      dvd   <= '0;
      rem   <= '0;
      dsr   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      ovf_r <= 1'b0;
      dz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd   <= bus.z;
            dsr   <= bus.y;
            rem   <= '0;
            count <= (bus.y == '0) ? '0 : CW'(DW);
          end
        end
        RUN: begin
          if (count != '0) begin
            dvd   <= {dvd[DW-2:0], fits};
            rem   <= fits ? trial[VW-1:0] : rem_sh[VW-1:0];
            count <= count - 1'b1;
          end else if (dsr == '0) begin
            q_r   <= '1;
            r_r   <= dvd[VW-1:0];
            ovf_r <= 1'b1;
            dz_r  <= 1'b1;
          end else begin
            q_r   <= dvd;
            r_r   <= rem;
            ovf_r <= |dvd[DW-1:VW];
            dz_r  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_8by4.sv
// tb_seq_div_8by4
// Purpose: scoreboard bench for seq_div_8by4. Stimulus pushes the expected
//          result into a queue; a monitor pops and compares on every done.
// Ports: none (top-level bench).
module tb_seq_div_8by4;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       ovf;
    logic       dz;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  seq_div_8by4_if #(.DW(8), .VW(4)) bus ();

  seq_div_8by4 #(.DW(8), .VW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done with q=%0d r=%0d, expected no done", bus.q, bus.r);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("q",   int'(bus.q),   int'(e.q));
        checkOutput("r",   int'(bus.r),   int'(e.r));
        checkOutput("ovf", int'(bus.ovf), int'(e.ovf));
        checkOutput("dz",  int'(bus.dz),  int'(e.dz));
      end
    end
  end

  // Issue one divide and wait (bounded) for its done. With inject set, a
  // second start carrying 10/3 is pulsed while busy and must be ignored.
  // Operands are scrambled right after acceptance to show they are latched.
  task automatic applyStimulus(input logic [7:0] zv, input logic [3:0] yv,
                               input logic [7:0] eq, input logic [3:0] er,
                               input logic eovf, input logic edz,
                               input int elat, input bit inject);
    exp_t e;
    int   busy_cnt;
    bit   seen;
    e.q = eq; e.r = er; e.ovf = eovf; e.dz = edz;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.z     = zv;
    bus.y     = yv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.z     = ~zv;
    bus.y     = ~yv;
    busy_cnt  = 0;
    seen      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (inject && i == 3) begin
        bus.start = 1'b1;
        bus.z     = 8'd10;
        bus.y     = 4'd3;
      end
      if (inject && i == 4) bus.start = 1'b0;
      @(negedge clk);
    end
    checkOutput("done_seen", int'(seen), 1);
    checkOutput("busy_cycles", busy_cnt, elat);
  endtask

  // Abort a running divide with reset and confirm it never completes.
  task automatic resetMidRun();
    int done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.z     = 8'd143;
    bus.y     = 4'd13;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_q",    int'(bus.q),    0);
    checkOutput("rst_r",    int'(bus.r),    0);
    checkOutput("rst_ovf",  int'(bus.ovf),  0);
    checkOutput("rst_dz",   int'(bus.dz),   0);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    checkOutput("abort_no_done", done_cnt, 0);
  endtask

  // Main sequence of directed vectors.
  initial begin
    int done_cnt;
    exp_t e;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.z       = '0;
    bus.y       = '0;
    repeat (2) @(negedge clk);
    checkOutput("init_busy", int'(bus.busy), 0);
    checkOutput("init_done", int'(bus.done), 0);
    checkOutput("init_q",    int'(bus.q),    0);
    checkOutput("init_dz",   int'(bus.dz),   0);
    rst_n = 1'b1;

    applyStimulus(8'd143, 4'd13, 8'd11,  4'd0,  1'b0, 1'b0, 9, 1'b0);
    applyStimulus(8'd200, 4'd7,  8'd28,  4'd4,  1'b1, 1'b0, 9, 1'b0);
    applyStimulus(8'd255, 4'd1,  8'd255, 4'd0,  1'b1, 1'b0, 9, 1'b0);
    applyStimulus(8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 1'b0, 9, 1'b0);
    applyStimulus(8'd77,  4'd0,  8'd255, 4'd13, 1'b1, 1'b1, 1, 1'b0);
    applyStimulus(8'd143, 4'd13, 8'd11,  4'd0,  1'b0, 1'b0, 9, 1'b1);
    applyStimulus(8'd10,  4'd3,  8'd3,   4'd1,  1'b0, 1'b0, 9, 1'b0);

    resetMidRun();
    applyStimulus(8'd225, 4'd15, 8'd15,  4'd0,  1'b0, 1'b0, 9, 1'b0);

    // Start held high: two back-to-back runs, each with exactly one done.
    e.q = 8'd11; e.r = 4'd1; e.ovf = 1'b0; e.dz = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.z     = 8'd100;
    bus.y     = 4'd9;
    done_cnt  = 0;
    for (int i = 0; i < 40 && done_cnt < 2; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    bus.start = 1'b0;
    checkOutput("b2b_dones", done_cnt, 2);

    // Round-trip sweep over every multiplier product with a nonzero factor.
    for (int yv = 1; yv < 16; yv++) begin
      for (int xv = 0; xv < 256; xv++) begin
        if (xv * yv < 256)
          applyStimulus(8'(xv * yv), 4'(yv), 8'(xv), 4'd0, (xv > 15), 1'b0, 9, 1'b0);
      end
    end

    repeat (5) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
